// File: rtl/rvv_wb_arbiter.sv
// rvv_wb_arbiter: round-robin arbiter sharing one registered write-back port among N requesters.
// Define RVV_ARB_URGENT_EN to add the req_urgent port and a strict urgent-first class.
module rvv_wb_arbiter #(
   parameter  int N  = 4,
   parameter  int DW = 32,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
`ifdef RVV_ARB_URGENT_EN
   input  logic [N-1:0]    req_urgent,
`endif
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [SW-1:0]   out_src,
   input  logic            out_ready,
   output logic            busy
);

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q,  out_data_d;
   logic [SW-1:0] out_src_q,   out_src_d;
   logic [SW-1:0] ptr_q,       ptr_d;

   logic [N-1:0]  eligible;
   logic [N-1:0]  hi_mask;
   logic [N-1:0]  masked;
   logic [N-1:0]  pick;
   logic [SW-1:0] win;
   logic          found;
   logic          can_take;
   logic          handshake;

`ifdef RVV_ARB_URGENT_EN
   logic [N-1:0]  urgent_valid;

   // Urgent requesters, when any are valid, hide everyone else from the scan.
   assign urgent_valid = req_valid & req_urgent;
   assign eligible     = (|urgent_valid) ? urgent_valid : req_valid;
`else
   assign eligible     = req_valid;
`endif

   assign can_take  = !flush && !rst && (!out_valid_q || out_ready);
   assign handshake = can_take && found;

   // Wrap-around scan: lowest eligible index at or above ptr, else lowest overall.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (i >= int'(ptr_q));
      end
      masked = eligible & hi_mask;
      pick   = (|masked) ? masked : eligible;
      found  = |eligible;
      win    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) begin
            win = SW'(i);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (handshake) begin
         req_ready[win] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (flush) begin
         out_valid_d = 1'b0;
         ptr_d       = '0;
      end else if (handshake) begin
         out_valid_d = 1'b1;
         out_data_d  = req_data[int'(win)*DW +: DW];
         out_src_d   = win;
         ptr_d       = (win == SW'(N - 1)) ? '0 : win + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; payload is reset too so out_data reads 0 after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = out_valid_q || (|req_valid);

endmodule

// File: tb/tb_rvv_wb_arbiter.sv
// tb_rvv_wb_arbiter: vector table, corner-case sequences and randomized traffic
// checked against a distance-based round-robin reference model.
module tb_rvv_wb_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = $clog2(N);
`ifdef RVV_ARB_URGENT_EN
   localparam bit URG_EN = 1'b1;
`else
   localparam bit URG_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst, flush, out_ready;
   logic [N-1:0]    req_valid, req_ready, req_urgent;
   logic [N*DW-1:0] req_data;
   logic            out_valid, busy;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rvv_wb_arbiter #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
`ifdef RVV_ARB_URGENT_EN
      .req_urgent(req_urgent),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: output register contents and rotation pointer as plain integers.
   bit            m_ov;
   logic [DW-1:0] m_data;
   int            m_src;
   int            m_ptr;

   function automatic int model_winner(input logic [N-1:0] v, input logic [N-1:0] u);
      logic [N-1:0] cand;
      int best, bestd, d;
      cand  = (URG_EN && ((v & u) != '0)) ? (v & u) : v;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         d = (i - m_ptr + N) % N;
         if (cand[i] && d < bestd) begin
            best  = i;
            bestd = d;
         end
      end
      return best;
   endfunction

   task automatic model_clock(input logic r, input logic f, input logic ordy,
                              input int g, input logic [DW-1:0] d);
      if (r) begin
         m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      end else if (f) begin
         m_ov = 1'b0; m_ptr = 0;
      end else if (g >= 0) begin
         m_ov = 1'b1; m_data = d; m_src = g; m_ptr = (g + 1) % N;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
   endtask

   typedef struct {
      logic          rst;
      logic          flush;
      logic          ordy;
      logic [N-1:0]  valid;
      logic [N-1:0]  exp_rdy;
      logic          exp_ov;
      int            exp_src;
      logic [DW-1:0] exp_data;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic f, input logic o, input logic [N-1:0] v,
                               input logic [N-1:0] er, input logic eov, input int es,
                               input logic [DW-1:0] ed);
      vec_t t;
      t.rst = r; t.flush = f; t.ordy = o; t.valid = v;
      t.exp_rdy = er; t.exp_ov = eov; t.exp_src = es; t.exp_data = ed;
      return t;
   endfunction

   task automatic drive_fixed_data();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA5A5_0000 + i;
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; req_valid = '0; req_urgent = '0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0]  pend;
      logic [DW-1:0] pd [N];
      int            waits [N];
      logic [N-1:0]  er;
      int            w, g, hs, waited;
      logic          r_i, f_i, o_i;

      rst = 1'b0; flush = 1'b0; req_valid = '0; req_urgent = '0; out_ready = 1'b1;
      req_data = '0;

      //          rst  flush ordy valid    exp_rdy  ov  src data
      tbl[0]  = mk(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 32'h0);
      tbl[1]  = mk(1, 0, 1, 4'b1111, 4'b0000, 0, 0, 32'h0);
      tbl[2]  = mk(0, 0, 1, 4'b1111, 4'b0001, 1, 0, 32'hA5A5_0000);
      tbl[3]  = mk(0, 0, 1, 4'b1111, 4'b0010, 1, 1, 32'hA5A5_0001);
      tbl[4]  = mk(0, 0, 1, 4'b1111, 4'b0100, 1, 2, 32'hA5A5_0002);
      tbl[5]  = mk(0, 0, 1, 4'b1111, 4'b1000, 1, 3, 32'hA5A5_0003);
      tbl[6]  = mk(0, 0, 1, 4'b1111, 4'b0001, 1, 0, 32'hA5A5_0000);
      tbl[7]  = mk(0, 0, 1, 4'b1000, 4'b1000, 1, 3, 32'hA5A5_0003);
      tbl[8]  = mk(0, 0, 1, 4'b1001, 4'b0001, 1, 0, 32'hA5A5_0000);
      tbl[9]  = mk(0, 0, 1, 4'b0100, 4'b0100, 1, 2, 32'hA5A5_0002);
      tbl[10] = mk(0, 0, 0, 4'b0100, 4'b0000, 1, 2, 32'hA5A5_0002);
      tbl[11] = mk(0, 0, 0, 4'b0100, 4'b0000, 1, 2, 32'hA5A5_0002);
      tbl[12] = mk(0, 0, 0, 4'b0100, 4'b0000, 1, 2, 32'hA5A5_0002);
      tbl[13] = mk(0, 0, 1, 4'b0100, 4'b0100, 1, 2, 32'hA5A5_0002);
      tbl[14] = mk(0, 0, 1, 4'b0000, 4'b0000, 0, 2, 32'hA5A5_0002);
      tbl[15] = mk(0, 0, 1, 4'b0010, 4'b0010, 1, 1, 32'hA5A5_0001);
      tbl[16] = mk(0, 1, 1, 4'b0010, 4'b0000, 0, 1, 32'hA5A5_0001);
      tbl[17] = mk(0, 0, 1, 4'b1010, 4'b0010, 1, 1, 32'hA5A5_0001);
      tbl[18] = mk(1, 1, 0, 4'b0100, 4'b0000, 0, 0, 32'h0);
      tbl[19] = mk(0, 0, 1, 4'b1100, 4'b0100, 1, 2, 32'hA5A5_0002);

      drive_fixed_data();
      for (int r = 0; r < NV; r++) begin
         @(negedge clk);
         rst = tbl[r].rst; flush = tbl[r].flush; out_ready = tbl[r].ordy;
         req_valid = tbl[r].valid; req_urgent = '0;
         #1;
         check($sformatf("vec%0d req_ready", r), req_ready, tbl[r].exp_rdy);
         @(posedge clk); #1;
         check($sformatf("vec%0d out_valid", r), out_valid, tbl[r].exp_ov);
         check($sformatf("vec%0d out_src", r), out_src, tbl[r].exp_src);
         check($sformatf("vec%0d out_data", r), out_data, tbl[r].exp_data);
      end

      // Full throughput: one handshake per cycle with every requester valid.
      reset_cycle();
      req_valid = '1; out_ready = 1'b1;
      hs = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if ((req_valid & req_ready) != '0) hs++;
         @(negedge clk);
      end
      check("throughput handshakes", hs, 8);
      check("throughput out_valid", out_valid, 1'b1);

      // Bounded wait for first-beat latency, then a stall must block new grants.
      req_valid = '0;
      @(negedge clk);
      req_valid = 4'b0010; out_ready = 1'b0;
      waited = 0;
      while (out_valid !== 1'b1 && waited < 4) begin
         @(posedge clk); #1;
         waited++;
      end
      check("latency cycles", waited, 1);
      check("latency src", out_src, 1);
      check("stall req_ready", req_ready, 4'b0000);
      check("busy while held", busy, 1'b1);

`ifdef RVV_ARB_URGENT_EN
      reset_cycle();
      req_valid = 4'b0011; req_urgent = 4'b0010; out_ready = 1'b1;
      #1;
      check("urgent grant", req_ready, 4'b0010);
      @(negedge clk);
      req_urgent = '0;
      #1;
      check("urgent cleared grant", req_ready, 4'b0001);
`endif

      // Randomized traffic against the reference model.
      reset_cycle();
      m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      pend = '0;
      for (int i = 0; i < N; i++) begin
         waits[i] = 0;
         pd[i]    = '0;
      end
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom % 2 == 0)) begin
               pend[i] = 1'b1;
               pd[i]   = $urandom;
            end
            req_data[i*DW +: DW] = pd[i];
         end
         r_i = ($urandom % 64 == 0);
         f_i = ($urandom % 16 == 0);
         o_i = ($urandom % 10 < 7);
         rst = r_i; flush = f_i; out_ready = o_i; req_valid = pend;
         req_urgent = URG_EN ? N'($urandom) : '0;
         #1;
         w  = model_winner(req_valid, req_urgent);
         er = (r_i || f_i || (m_ov && !o_i) || w < 0) ? '0 : (N'(1) << w);
         g  = (er != '0) ? w : -1;
         check("rand req_ready", req_ready, er);
         check("rand busy", busy, m_ov || (req_valid != '0));
         if (!URG_EN && g >= 0) check("rand fairness", waits[g] <= N - 1, 1'b1);
         if (r_i || f_i) begin
            for (int i = 0; i < N; i++) waits[i] = 0;
         end else if (g >= 0) begin
            for (int i = 0; i < N; i++) if (pend[i] && i != g) waits[i]++;
            waits[g] = 0;
         end
         @(posedge clk);
         model_clock(r_i, f_i, o_i, g, (g >= 0) ? pd[g] : '0);
         if (g >= 0) pend[g] = 1'b0;
         #1;
         check("rand out_valid", out_valid, m_ov);
         check("rand out_src", out_src, m_src);
         check("rand out_data", out_data, m_data);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
